dcache_controller: RTL and testbench

Blocking write-back controller that sits between the CPU memory stage and the 256-bit main-memory port and drives the 16-set, 2-way data cache SRAM as the initiator on that interface. It decodes CPU loads and stores into SRAM lookups, returns the selected word on a hit, and stalls the CPU on a miss. On a miss it writes back a dirty victim, fetches the line, fills it, and replays the access.

---
 rtl/dcache_pkg.sv | 27 ++
 rtl/dcache_word_merge.sv | 20 ++
 rtl/dcache_controller.sv | 192 +++++++++++++++++++
 tb/tb_dcache_controller.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared field widths, tag layout and FSM states
// for the blocking write-back data-cache controller.
package dcache_pkg;

  localparam int TAG_W  = 23;
  localparam int IDX_W  = 4;
  localparam int LINE_W = 256;

  localparam int VALID = 24;
  localparam int DIRTY = 23;

  typedef enum logic [2:0] {
    IDLE,
    MISS,
    WRITEBACK,
    READMISS,
    READMISSOK
  } state_e;

  function automatic logic [31:0] line_addr(
    input logic [TAG_W-1:0] tag,
    input logic [IDX_W-1:0] idx
  );
    return {tag, idx, 5'b0};
  endfunction

endpackage

// File: rtl/dcache_word_merge.sv
// Extracts one 32-bit word from a cache line and
// builds the same line with that word replaced.
module dcache_word_merge
  import dcache_pkg::*;
(
  input  logic [LINE_W-1:0] line_i,
  input  logic [2:0]        sel_i,
  input  logic [31:0]       word_i,
  output logic [31:0]       word_o,
  output logic [LINE_W-1:0] line_o
);

  assign word_o = line_i[32*sel_i +: 32];

  always_comb begin
    line_o = line_i;
    line_o[32*sel_i +: 32] = word_i;
  end

endmodule

// File: rtl/dcache_controller.sv
// Blocking write-back controller between the CPU memory
// stage, the 2-way cache SRAM and the 256-bit memory port.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int MEM_LAT_MAX = 1023
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_data_i,
  input  logic              cpu_MemRead_i,
  input  logic              cpu_MemWrite_i,
  output logic [31:0]       cpu_data_o,
  output logic              cpu_stall_o,
  output logic [3:0]        sram_addr_o,
  output logic [24:0]       sram_tag_o,
  output logic [LINE_W-1:0] sram_data_o,
  output logic              sram_enable_o,
  output logic              sram_write_o,
  output logic              sram_write_hit_o,
  input  logic [24:0]       sram_tag_i,
  input  logic [LINE_W-1:0] sram_data_i,
  input  logic              sram_hit_i,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);

  state_e              state_q, state_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [24:0]         vic_tag_q, vic_tag_d;
  logic [LINE_W-1:0]   vic_data_q, vic_data_d;
  logic [LINE_W-1:0]   fill_q, fill_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [31:0]         mem_addr_q, mem_addr_d;
  logic [31:0]         lat_q, lat_d;

  logic                act;
  logic                whit;
  logic [TAG_W-1:0]    cpu_tag;
  logic [IDX_W-1:0]    cpu_idx;
  logic [LINE_W-1:0]   merged;
  logic                unused_addr;

  assign cpu_tag     = cpu_addr_i[31:9];
  assign cpu_idx     = cpu_addr_i[8:5];
  assign unused_addr = ^cpu_addr_i[1:0];

  // Reset abandons the request at once, even mid-cycle.
  assign act  = rst_i & (cpu_MemRead_i | cpu_MemWrite_i);
  assign whit = act & cpu_MemWrite_i & sram_hit_i
              & (state_q == IDLE);

  dcache_word_merge u_merge (
    .line_i (sram_data_i),
    .sel_i  (cpu_addr_i[4:2]),
    .word_i (cpu_data_i),
    .word_o (cpu_data_o),
    .line_o (merged)
  );

  always_comb begin
    state_d    = state_q;
    tag_d      = tag_q;
    idx_d      = idx_q;
    vic_tag_d  = vic_tag_q;
    vic_data_d = vic_data_q;
    fill_d     = fill_q;
    mem_en_d   = mem_en_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    unique case (state_q)
      IDLE: begin
        if (act & ~sram_hit_i) begin
          state_d    = MISS;
          tag_d      = cpu_tag;
          idx_d      = cpu_idx;
          vic_tag_d  = sram_tag_i;
          vic_data_d = sram_data_i;
        end
      end
      MISS: begin
        mem_en_d = 1'b1;
        if (vic_tag_q[VALID] & vic_tag_q[DIRTY]) begin
          state_d    = WRITEBACK;
          mem_we_d   = 1'b1;
          mem_addr_d = line_addr(vic_tag_q[TAG_W-1:0], idx_q);
        end else begin
          state_d    = READMISS;
          mem_we_d   = 1'b0;
          mem_addr_d = line_addr(tag_q, idx_q);
        end
      end
      WRITEBACK: begin
        if (mem_ack_i) begin
          state_d    = READMISS;
          mem_we_d   = 1'b0;
          mem_addr_d = line_addr(tag_q, idx_q);
        end
      end
      READMISS: begin
        if (mem_ack_i) begin
          state_d    = READMISSOK;
          fill_d     = mem_data_i;
          mem_en_d   = 1'b0;
          mem_addr_d = '0;
        end
      end
      READMISSOK: state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  assign lat_d = (mem_en_q & ~mem_ack_i) ? lat_q + 32'd1 : '0;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      tag_q      <= '0;
      idx_q      <= '0;
      vic_tag_q  <= '0;
      vic_data_q <= '0;
      fill_q     <= '0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      lat_q      <= '0;
    end else begin
      state_q    <= state_d;
      tag_q      <= tag_d;
      idx_q      <= idx_d;
      vic_tag_q  <= vic_tag_d;
      vic_data_q <= vic_data_d;
      fill_q     <= fill_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      lat_q      <= lat_d;
    end
  end

  assign mem_enable_o = mem_en_q;
  assign mem_write_o  = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_we_q ? vic_data_q : '0;

  always_comb begin
    cpu_stall_o      = 1'b0;
    sram_enable_o    = 1'b0;
    sram_write_o     = 1'b0;
    sram_write_hit_o = 1'b0;
    sram_addr_o      = idx_q;
    sram_tag_o       = {2'b00, tag_q};
    sram_data_o      = '0;
    unique case (state_q)
      IDLE: begin
        sram_addr_o      = cpu_idx;
        sram_tag_o       = {whit, whit, cpu_tag};
        sram_enable_o    = act;
        cpu_stall_o      = act & ~sram_hit_i;
        sram_write_o     = whit;
        sram_write_hit_o = whit;
        sram_data_o      = whit ? merged : '0;
      end
      MISS: begin
        sram_enable_o = 1'b1;
        cpu_stall_o   = 1'b1;
      end
      WRITEBACK, READMISS: cpu_stall_o = 1'b1;
      READMISSOK: begin
        sram_enable_o = 1'b1;
        sram_write_o  = 1'b1;
        cpu_stall_o   = 1'b1;
        sram_tag_o    = {2'b10, tag_q};
        sram_data_o   = fill_q;
      end
      default: cpu_stall_o = 1'b0;
    endcase
  end

  a_mem_lat: assert property (
    @(posedge clk_i) disable iff (!rst_i)
    !(mem_en_q && lat_q >= MEM_LAT_MAX)
  );

endmodule

// File: tb/tb_dcache_controller.sv
// Random and directed bench for dcache_controller against
// a flat word-memory reference, with SRAM and memory models.
module tb_dcache_controller;

  logic         clk, rst_i;
  logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o;
  logic         cpu_MemRead_i, cpu_MemWrite_i, cpu_stall_o;
  logic [3:0]   sram_addr_o;
  logic [24:0]  sram_tag_o, sram_tag_i;
  logic [255:0] sram_data_o, sram_data_i;
  logic         sram_enable_o, sram_write_o, sram_write_hit_o, sram_hit_i;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o, mem_data_i;
  logic         mem_enable_o, mem_write_o, mem_ack_i;

  dcache_controller #(.MEM_LAT_MAX(1023)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
    .cpu_MemRead_i(cpu_MemRead_i), .cpu_MemWrite_i(cpu_MemWrite_i),
    .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
    .sram_addr_o(sram_addr_o), .sram_tag_o(sram_tag_o),
    .sram_data_o(sram_data_o), .sram_enable_o(sram_enable_o),
    .sram_write_o(sram_write_o), .sram_write_hit_o(sram_write_hit_o),
    .sram_tag_i(sram_tag_i), .sram_data_i(sram_data_i),
    .sram_hit_i(sram_hit_i),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic finish_sim();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  endtask

  // Reference: flat word memory, plus the backing line memory.
  logic [31:0]  ref_mem [bit [29:0]];
  logic [255:0] mem_line [bit [26:0]];

  function automatic logic [31:0] init_word(input bit [29:0] wa);
    return 32'(wa) * 32'h9E3779B1 + 32'h0123_4567;
  endfunction

  function automatic logic [31:0] ref_get(input logic [31:0] a);
    bit [29:0] wa;
    wa = a[31:2];
    if (ref_mem.exists(wa)) return ref_mem[wa];
    return init_word(wa);
  endfunction

  function automatic logic [255:0] mem_get(input bit [26:0] la);
    logic [255:0] l;
    if (mem_line.exists(la)) return mem_line[la];
    for (int k = 0; k < 8; k++) l[32*k +: 32] = init_word({la, 3'(k)});
    return l;
  endfunction

  // Cache SRAM model: 16 sets x 2 ways with one LRU bit per set.
  logic [24:0]  st_tag  [16][2];
  logic [255:0] st_data [16][2];
  logic         lru [16];
  logic         clr, pre_en, pre_way;
  logic [3:0]   pre_set;
  logic [24:0]  pre_tag;
  logic [255:0] pre_data;
  logic [3:0]   lk_idx;
  logic [22:0]  lk_tag;
  logic         h0, h1, hw, vw, ww;

  always_comb begin
    lk_idx = cpu_addr_i[8:5];
    lk_tag = cpu_addr_i[31:9];
    h0 = st_tag[lk_idx][0][24] && (st_tag[lk_idx][0][22:0] == lk_tag);
    h1 = st_tag[lk_idx][1][24] && (st_tag[lk_idx][1][22:0] == lk_tag);
    sram_hit_i = h0 | h1;
    hw = h1;
    vw = sram_hit_i ? hw : lru[lk_idx];
    sram_tag_i  = st_tag[lk_idx][vw];
    sram_data_i = st_data[lk_idx][vw];
  end

  always_comb begin
    ww = lru[sram_addr_o];
    if (sram_write_hit_o)
      ww = st_tag[sram_addr_o][1][24] &&
           (st_tag[sram_addr_o][1][22:0] == sram_tag_o[22:0]);
  end

  always @(posedge clk) begin
    if (clr) begin
      for (int s = 0; s < 16; s++) begin
        lru[s] <= 1'b0;
        for (int w = 0; w < 2; w++) begin
          st_tag[s][w]  <= '0;
          st_data[s][w] <= '0;
        end
      end
    end else if (pre_en) begin
      st_tag[pre_set][pre_way]  <= pre_tag;
      st_data[pre_set][pre_way] <= pre_data;
    end else if (sram_enable_o && sram_write_o) begin
      st_tag[sram_addr_o][ww]  <= sram_tag_o;
      st_data[sram_addr_o][ww] <= sram_data_o;
      lru[sram_addr_o] <= ~ww;
    end else if (sram_enable_o && sram_hit_i) begin
      lru[lk_idx] <= ~hw;
    end
  end

  // Memory responder with per-request latency.
  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } mlog_t;
  mlog_t mlog[$];
  int lat_rd = 0, lat_wr = 0;
  bit resp_en = 1, inject_ack = 0;
  int cnt = 0, lat = 1;
  logic [31:0] req_addr;

  initial begin
    mem_ack_i = 1'b0;
    mem_data_i = '0;
    forever begin
      @(negedge clk);
      mem_ack_i = 1'b0;
      if (!rst_i || !resp_en) cnt = 0;
      if (!resp_en) mem_ack_i = inject_ack;
      else if (rst_i && mem_enable_o) begin
        cnt++;
        if (cnt == 1) begin
          req_addr = mem_addr_o;
          if (mem_write_o) lat = lat_wr != 0 ? lat_wr : int'($urandom_range(1, 4));
          else lat = lat_rd != 0 ? lat_rd : int'($urandom_range(1, 4));
        end
        if (cnt == lat) begin
          mem_ack_i = 1'b1;
          cnt = 0;
          chk("mem_addr_align", mem_addr_o[4:0], 5'd0);
          chk("mem_addr_stable", mem_addr_o, req_addr);
          mlog.push_back('{mem_write_o, mem_addr_o, mem_data_o});
          if (mem_write_o) mem_line[mem_addr_o[31:5]] = mem_data_o;
          else mem_data_i = mem_get(mem_addr_o[31:5]);
        end
      end
    end
  end

  // Scoreboard: expected responses queued at issue, checked on completion.
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  logic [255:0] exp_line;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_i && (cpu_MemRead_i || cpu_MemWrite_i) && !cpu_stall_o) begin
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          e = sb.pop_front();
          chk("sb_addr", cpu_addr_i, e.addr);
          if (!e.wr) chk("load_data", cpu_data_o, e.data);
          else begin
            exp_line = sram_data_i;
            exp_line[32*e.addr[4:2] +: 32] = e.data;
            chk("store_wr", {sram_write_o, sram_write_hit_o}, 2'b11);
            chk("store_tag", sram_tag_o, {2'b11, e.addr[31:9]});
            chk("store_line", sram_data_o, exp_line);
          end
        end
      end
    end
  end

  int stalls;
  bit mem_seen;
  logic [24:0] last_fill;

  task automatic access(input bit wr, input bit rd_too,
                        input logic [31:0] a, input logic [31:0] d);
    bit done;
    @(posedge clk); #1;
    cpu_addr_i = a;
    cpu_data_i = d;
    cpu_MemWrite_i = wr;
    cpu_MemRead_i = wr ? rd_too : 1'b1;
    if (wr) begin
      ref_mem[a[31:2]] = d;
      sb.push_back('{1'b1, a, d});
    end else sb.push_back('{1'b0, a, ref_get(a)});
    stalls = 0;
    mem_seen = 0;
    done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (mem_enable_o) mem_seen = 1;
      if (sram_write_o && !sram_write_hit_o) last_fill = sram_tag_o;
      if (!cpu_stall_o) done = 1;
      else stalls++;
    end
    if (!done) begin
      chk("access_timeout", 1, 0);
      finish_sim();
    end
  endtask

  task automatic preload(input int s, input logic [22:0] t,
                         input logic [255:0] line);
    @(posedge clk); #1;
    cpu_MemRead_i = 0;
    cpu_MemWrite_i = 0;
    pre_en = 1;
    pre_set = 4'(s);
    pre_way = 0;
    pre_tag = {2'b11, t};
    pre_data = line;
    @(posedge clk); #1;
    pre_en = 0;
    for (int k = 0; k < 8; k++) ref_mem[{t, 4'(s), 3'(k)}] = line[32*k +: 32];
  endtask

  initial begin
    #400000;
    n_chk++;
    $display("FAIL watchdog: time limit reached");
    finish_sim();
  end

  logic [255:0] l0, l8, l2;
  int rm;

  initial begin
    rst_i = 0; clr = 1; pre_en = 0; pre_way = 0; pre_set = 0;
    pre_tag = '0; pre_data = '0; last_fill = '0;
    cpu_addr_i = 0; cpu_data_i = 0;
    cpu_MemRead_i = 0; cpu_MemWrite_i = 0;
    repeat (3) @(negedge clk);
    chk("rst_stall", cpu_stall_o, 0);
    chk("rst_mem_en", mem_enable_o, 0);
    chk("rst_sram_wr", sram_write_o, 0);
    @(posedge clk); #1;
    rst_i = 1; clr = 0;

    for (int k = 0; k < 8; k++) l0[32*k +: 32] = $urandom;
    l0[96 +: 32] = 32'hDEADBEEF;
    preload(0, 23'h0, l0);
    access(0, 0, 32'h0000_000C, 0);
    chk("rdhit_data", cpu_data_o, 32'hDEADBEEF);
    chk("rdhit_stall", stalls, 0);
    chk("rdhit_mem_quiet", mem_seen, 0);

    for (int k = 0; k < 8; k++) l8[32*k +: 32] = $urandom;
    preload(8, 23'h0, l8);
    access(1, 0, 32'h0000_0104, 32'h12345678);
    chk("wrhit_stall", stalls, 0);
    chk("wrhit_word", sram_data_o[32 +: 32], 32'h12345678);
    chk("wrhit_other", sram_data_o[64 +: 192], l8[64 +: 192]);
    access(0, 0, 32'h0000_0104, 0);

    lat_rd = 10;
    mlog.delete();
    access(0, 0, 32'h0000_0220, 0);
    chk("clean_stall", stalls, 13);
    chk("clean_nreq", mlog.size(), 1);
    if (mlog.size() == 1) begin
      chk("clean_addr", mlog[0].addr, 32'h220);
      chk("clean_wr", mlog[0].wr, 0);
    end
    chk("clean_fill_tag", last_fill, 25'h100_0001);

    for (int k = 0; k < 8; k++) l2[32*k +: 32] = $urandom;
    preload(2, 23'h7, l2);
    lat_wr = 10;
    mlog.delete();
    access(0, 0, 32'h0000_0040, 0);
    chk("dirty_stall", stalls, 23);
    chk("dirty_nreq", mlog.size(), 2);
    if (mlog.size() == 2) begin
      chk("dirty_wb", {mlog[0].wr, mlog[0].addr}, {1'b1, 32'hE40});
      chk("dirty_wb_data", mlog[0].data, l2);
      chk("dirty_rd", {mlog[1].wr, mlog[1].addr}, {1'b0, 32'h40});
    end

    lat_rd = 3; lat_wr = 0;
    access(1, 0, 32'h0000_0460, 32'hAAAA5555);
    chk("stmiss_stall", stalls, 6);
    chk("stmiss_fill_tag", last_fill, 25'h100_0002);
    access(0, 0, 32'h0000_0460, 0);
    access(0, 0, 32'h0000_0E44, 0);

    lat_rd = 0;
    for (int i = 0; i < 250; i++) begin
      logic [31:0] a;
      a = {21'h0, 2'($urandom_range(0, 3)), 4'($urandom), 3'($urandom), 2'b00};
      access(1'($urandom), 1'($urandom), a, $urandom);
    end

    lat_rd = 100; lat_wr = 2;
    @(posedge clk); #1;
    cpu_addr_i = 32'h0000_0CA0;
    cpu_MemRead_i = 1; cpu_MemWrite_i = 0;
    sb.push_back('{1'b0, 32'h0000_0CA0, ref_get(32'h0000_0CA0)});
    rm = 0;
    for (int i = 0; i < 300 && rm < 4; i++) begin
      @(negedge clk);
      if (mem_enable_o && !mem_write_o) rm++;
    end
    chk("rst_reach_rm4", rm, 4);
    rst_i = 0;
    #1;
    chk("midrst_mem_en", mem_enable_o, 0);
    chk("midrst_stall", cpu_stall_o, 0);
    void'(sb.pop_back());
    cpu_MemRead_i = 0;
    resp_en = 0;
    @(negedge clk);
    @(posedge clk); #1;
    rst_i = 1;
    inject_ack = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 1) inject_ack = 0;
      chk("late_ack_mem_en", mem_enable_o, 0);
      chk("late_ack_stall", cpu_stall_o, 0);
    end
    resp_en = 1;
    lat_rd = 0; lat_wr = 0;
    access(0, 0, 32'h0000_0CA0, 0);
    for (int i = 0; i < 20; i++) begin
      logic [31:0] a;
      a = {21'h0, 2'($urandom_range(0, 3)), 4'($urandom), 3'($urandom), 2'b00};
      access(1'($urandom), 1'($urandom), a, $urandom);
    end
    @(posedge clk); #1;
    cpu_MemRead_i = 0; cpu_MemWrite_i = 0;
    repeat (2) @(negedge clk);
    chk("sb_drain", sb.size(), 0);
    finish_sim();
  end

endmodule
